// File: rtl/led_frame_scheduler.sv
// LED strip refresh sequencer: bank swap, driver start/finish handshake, latch gap, periodic re-send.
// Optional SEND watchdog is enabled by defining LED_SCHED_WATCHDOG_EN.
module led_frame_scheduler #(
  parameter int unsigned LATCH_CYCLES   = 1000,
  parameter int unsigned REFRESH_CYCLES = 400000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_ready,
  output logic        frame_ack,
  output logic        rd_bank,
  output logic        wr_bank,
  output logic        drv_start,
  input  logic        drv_finish,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        error
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_LATCH} state_t;

  state_t      r_state;
  logic        r_pending;
  logic        r_refresh_due;
  logic [31:0] r_refresh_cnt;
  logic [31:0] r_latch_cnt;

  logic w_new_frame;
  logic w_refresh_hit;
  logic w_start;
  logic w_timeout;

  // The terminal refresh count counts as due in the same cycle, so restarts are exactly REFRESH_CYCLES apart.
  assign w_new_frame   = r_pending | frame_ready;
  assign w_refresh_hit = (REFRESH_CYCLES != 0) && (r_refresh_cnt == REFRESH_CYCLES - 1);
  assign w_start       = (r_state == S_IDLE) && enable &&
                         (w_new_frame || r_refresh_due || w_refresh_hit);
  assign wr_bank       = ~rd_bank;

  // NOTE: every register below is updated with <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_refresh_due <= 1'b1;
    end else if (w_start) begin
      r_refresh_cnt <= '0;
      r_refresh_due <= 1'b0;
    end else if (w_refresh_hit) begin
      r_refresh_due <= 1'b1;
    end else if (REFRESH_CYCLES != 0) begin
      r_refresh_cnt <= r_refresh_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_latch_cnt <= '0;
      rd_bank     <= 1'b0;
      frame_ack   <= 1'b0;
      drv_start   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_ack <= 1'b0;
      drv_start <= 1'b0;

      if (w_start && w_new_frame) r_pending <= 1'b0;
      else if (frame_ready)       r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_START;
            drv_start <= 1'b1;
            busy      <= 1'b1;
            if (w_new_frame) begin
              rd_bank   <= ~rd_bank;
              frame_ack <= 1'b1;
            end
          end
        end
        S_START: r_state <= S_SEND;
        S_SEND: begin
          if (drv_finish) begin
            frame_count <= frame_count + 16'd1;
            r_latch_cnt <= LATCH_CYCLES - 1;
            r_state     <= S_LATCH;
          end else if (w_timeout) begin
            r_latch_cnt <= LATCH_CYCLES - 1;
            r_state     <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (r_latch_cnt == '0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_latch_cnt <= r_latch_cnt - 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LED_SCHED_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_error;

  // Counter is 0 in the first SEND cycle, so the timeout fires after exactly TIMEOUT_CYCLES SEND cycles.
  assign w_timeout = (r_state == S_SEND) && (r_wd_cnt == TIMEOUT_CYCLES - 1);
  assign error     = r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_START)     r_wd_cnt <= '0;
      else if (r_state == S_SEND) r_wd_cnt <= r_wd_cnt + 32'd1;
      if (w_timeout && !drv_finish) r_error <= 1'b1;
    end
  end
`else
  // Timeout parameter stays referenced so both builds share one parameter list; this folds to 0.
  assign w_timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
  assign error     = 1'b0;
`endif

endmodule
